// File: rtl/ldpc_encode_ctrl.sv
// ldpc_encode_ctrl
// Sequencing controller for the (6,3) LDPC encoder. A host writes the three
// 6-bit parity-check rows h1..h3. Systematic generator rows are derived from
// those rows. A 3-bit message is then accepted and its codeword is
// accumulated serially, one generator row per cycle. The finished 6-bit
// codeword is then offered downstream.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   cfg_we     write strobe for one parity-check row
//   cfg_sel    row select (1..3 -> h1..h3, 0 rejected)
//   cfg_data   row value
//   cfg_clear  drop all rows and return to the unconfigured state
//   cfg_err    one-cycle pulse after a rejected write or clear
//   msg_valid  message available
//   msg_data   message bits m[2:0]
//   msg_ready  controller can take a message
//   cw_valid   codeword available
//   cw_data    codeword c[5:0] (c[2:0] = m)
//   cw_ready   downstream takes the codeword
//   busy       encode in progress or codeword pending
module ldpc_encode_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_we,
  input  logic [1:0] cfg_sel,
  input  logic [5:0] cfg_data,
  input  logic       cfg_clear,
  output logic       cfg_err,
  input  logic       msg_valid,
  input  logic [2:0] msg_data,
  output logic       msg_ready,
  output logic       cw_valid,
  output logic [5:0] cw_data,
  input  logic       cw_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_UNCFG = 2'd0,
    S_READY = 2'd1,
    S_ACCUM = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t     state, state_nxt;

  logic [5:0] h1, h2, h3;
  logic [2:0] mask;
  logic [2:0] wr_bit;

  // Message and generator rows captured at acceptance, so the word in flight
  // never sees a row write made on the acceptance edge itself.
  logic [2:0] m_p0;
  logic [5:0] g1_p0, g2_p0, g3_p0;
  logic [5:0] acc_p1;
  logic [1:0] idx_p1;
  logic [5:0] cw_p2;
  logic       err_q;

  logic       in_cfg, wr_ok, clr_ok, accept, err_nxt;
  logic [5:0] g_sel, term;

  // Generator row for message bit i: the parity bits are column (5-i) of H,
  // and the identity part is a single one in position i.
  function automatic logic [5:0] gen_row(input logic b1, input logic b2,
                                         input logic b3, input logic [2:0] unit);
    gen_row = {b3, b2, b1, unit};
  endfunction

  assign in_cfg    = (state == S_UNCFG) || (state == S_READY);
  // A clear in the same cycle blocks acceptance, so clear always wins.
  assign msg_ready = (state == S_READY) && !cfg_clear;
  assign accept    = msg_valid && msg_ready;
  assign clr_ok    = cfg_clear && in_cfg;
  assign wr_ok     = cfg_we && in_cfg && !cfg_clear && (cfg_sel != 2'd0);
  assign err_nxt   = (cfg_we && (!in_cfg || (cfg_sel == 2'd0))) ||
                     (cfg_clear && !in_cfg);

  assign cw_valid  = (state == S_OUT);
  assign busy      = (state == S_ACCUM) || (state == S_OUT);
  assign cw_data   = cw_p2;
  assign cfg_err   = err_q;

  always_comb begin
    wr_bit = 3'b000;
    case (cfg_sel)
      2'd1:    wr_bit = 3'b001;
      2'd2:    wr_bit = 3'b010;
      2'd3:    wr_bit = 3'b100;
      default: wr_bit = 3'b000;
    endcase
  end

  always_comb begin
    g_sel = g1_p0;
    case (idx_p1)
      2'd0:    g_sel = g1_p0;
      2'd1:    g_sel = g2_p0;
      default: g_sel = g3_p0;
    endcase
    term = m_p0[idx_p1] ? g_sel : 6'd0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_UNCFG: begin
        if (wr_ok && ((mask | wr_bit) == 3'b111)) state_nxt = S_READY;
      end
      S_READY: begin
        if (clr_ok)      state_nxt = S_UNCFG;
        else if (accept) state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        if (idx_p1 == 2'd2) state_nxt = S_OUT;
      end
      S_OUT: begin
        if (cw_ready) state_nxt = S_READY;
      end
      default: state_nxt = S_UNCFG;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_UNCFG;
      err_q  <= 1'b0;
      h1     <= 6'd0;
      h2     <= 6'd0;
      h3     <= 6'd0;
      mask   <= 3'b000;
      m_p0   <= 3'd0;
      g1_p0  <= 6'd0;
      g2_p0  <= 6'd0;
      g3_p0  <= 6'd0;
      acc_p1 <= 6'd0;
      idx_p1 <= 2'd0;
      cw_p2  <= 6'd0;
    end else begin
      state <= state_nxt;
      err_q <= err_nxt;

      if (clr_ok) begin
        h1   <= 6'd0;
        h2   <= 6'd0;
        h3   <= 6'd0;
        mask <= 3'b000;
      end else if (wr_ok) begin
        case (cfg_sel)
          2'd1:    h1 <= cfg_data;
          2'd2:    h2 <= cfg_data;
          default: h3 <= cfg_data;
        endcase
        mask <= mask | wr_bit;
      end

      // Stage p0: capture message and generator rows (from pre-edge rows)
      if (accept) begin
        m_p0   <= msg_data;
        g1_p0  <= gen_row(h1[5], h2[5], h3[5], 3'b001);
        g2_p0  <= gen_row(h1[4], h2[4], h3[4], 3'b010);
        g3_p0  <= gen_row(h1[3], h2[3], h3[3], 3'b100);
        acc_p1 <= 6'd0;
        idx_p1 <= 2'd0;
      // Stage p1: serial accumulation, one generator row per cycle
      end else if (state == S_ACCUM) begin
        acc_p1 <= acc_p1 ^ term;
        if (idx_p1 == 2'd2) begin
          idx_p1 <= 2'd0;
          // Stage p2: final word held until the downstream handshake
          cw_p2  <= acc_p1 ^ term;
        end else begin
          idx_p1 <= idx_p1 + 2'd1;
        end
      end
    end
  end

endmodule
